// File: rtl/bt_cmd_scheduler.sv
// Purpose: shares the BLE AT-command encoder between host TX payloads and a periodic RX poll,
//          then streams each encoded frame to the UART LSB byte first.
// Latency: first uart byte is offered 4 cycles after the grant; backpressure: uart_ready_i stalls SEND with data held.
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   tx_valid_i/tx_data_i    host payload request; tx_ready_o is the combinational accept
//   poll_enable_i           runs the RX-poll timer
//   enc_*                   encoder start pulse, command select, payload, done level, encoded frame
//   uart_*                  byte stream to the UART transmitter (valid/ready)
//   busy_o, cmd_done_o, err_timeout_o, last_kind_o   status
module bt_cmd_scheduler #(
    parameter int POLL_PERIOD    = 1000000,
    parameter int ENC_TIMEOUT    = 255,
    parameter int TX_FRAME_BYTES = 18,
    parameter int RX_FRAME_BYTES = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_valid_i,
    input  logic [31:0]  tx_data_i,
    output logic         tx_ready_o,
    input  logic         poll_enable_i,
    output logic         enc_start_o,
    output logic [3:0]   enc_cmd_select_o,
    output logic [31:0]  enc_input_data_o,
    input  logic         enc_done_i,
    input  logic [143:0] enc_output_data_i,
    output logic [7:0]   uart_data_o,
    output logic         uart_valid_o,
    input  logic         uart_ready_i,
    output logic         busy_o,
    output logic         cmd_done_o,
    output logic         err_timeout_o,
    output logic         last_kind_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;

    localparam int PW   = $clog2(POLL_PERIOD);
    localparam int WW   = $clog2(ENC_TIMEOUT + 1);
    localparam int MAXB = (TX_FRAME_BYTES > RX_FRAME_BYTES) ? TX_FRAME_BYTES : RX_FRAME_BYTES;
    localparam int IW   = $clog2(MAXB + 1);

    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ENC_TIMEOUT - 1);
    localparam logic [IW-1:0] TX_LAST   = IW'(TX_FRAME_BYTES - 1);
    localparam logic [IW-1:0] RX_LAST   = IW'(RX_FRAME_BYTES - 1);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_pend_q, poll_pend_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [143:0]  frame_q, frame_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   in_data_q, in_data_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          last_kind_q, last_kind_d;

    logic          in_idle;
    logic          grant_tx;
    logic          grant_rx;
    logic          poll_wrap;
    logic [IW-1:0] last_idx;

    assign in_idle   = (state_q == ST_IDLE);
    // Round-robin: on a tie the kind opposite to the last grant wins.
    assign grant_tx  = in_idle && tx_valid_i && (!poll_pend_q || last_kind_q);
    assign grant_rx  = in_idle && poll_pend_q && (!tx_valid_i || !last_kind_q);
    assign poll_wrap = poll_enable_i && (poll_cnt_q == POLL_LAST);
    assign last_idx  = last_kind_q ? RX_LAST : TX_LAST;

    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = poll_cnt_q;
        poll_pend_d = poll_pend_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        sel_d       = sel_q;
        in_data_d   = in_data_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        last_kind_d = last_kind_q;

        if (!poll_enable_i || poll_wrap) begin
            poll_cnt_d = '0;
        end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
        // A wrap in the same cycle as an RX grant re-arms the poll.
        if (poll_wrap) begin
            poll_pend_d = 1'b1;
        end else if (grant_rx) begin
            poll_pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_tx || grant_rx) begin
                    state_d     = ST_START;
                    start_d     = 1'b1;
                    last_kind_d = grant_rx;
                    sel_d       = grant_rx ? 4'd2 : 4'd1;
                    in_data_d   = grant_tx ? tx_data_i : 32'd0;
                    wait_cnt_d  = '0;
                end
            end
            ST_START: begin
                state_d    = ST_WAIT_BUSY;
                wait_cnt_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (!enc_done_i) begin
                    state_d    = ST_WAIT_DONE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (enc_done_i) begin
                    frame_d = enc_output_data_i;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (uart_ready_i) begin
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            sel_q       <= 4'd0;
            in_data_q   <= 32'd0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_kind_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            poll_pend_q <= poll_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            sel_q       <= sel_d;
            in_data_q   <= in_data_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_kind_q <= last_kind_d;
        end
    end

    // tx_ready is a decode of live inputs; masking with reset keeps it low while reset is held.
    assign tx_ready_o       = grant_tx && !reset;
    assign enc_start_o      = start_q;
    assign enc_cmd_select_o = sel_q;
    assign enc_input_data_o = in_data_q;
    assign uart_valid_o     = (state_q == ST_SEND);
    assign uart_data_o      = frame_q[{idx_q, 3'b000} +: 8];
    assign busy_o           = !in_idle;
    assign cmd_done_o       = done_q;
    assign err_timeout_o    = err_q;
    assign last_kind_o      = last_kind_q;

endmodule

// File: tb/tb_bt_cmd_scheduler.sv
// Purpose: self-checking bench for bt_cmd_scheduler with an encoder model and a transaction-level reference.
// Latency: reference predicts outputs cycle by cycle from grant time; backpressure: uart_ready driven fixed, patterned or random.
module tb_bt_cmd_scheduler;
    localparam int P   = 20;
    localparam int T   = 8;
    localparam int NTX = 18;
    localparam int NRX = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tx_valid_i = 1'b0;
    logic [31:0]  tx_data_i = 32'd0;
    logic         tx_ready_o;
    logic         poll_enable_i = 1'b0;
    logic         enc_start_o;
    logic [3:0]   enc_cmd_select_o;
    logic [31:0]  enc_input_data_o;
    logic         enc_done_i = 1'b1;
    logic [143:0] enc_output_data_i = '0;
    logic [7:0]   uart_data_o;
    logic         uart_valid_o;
    logic         uart_ready_i = 1'b1;
    logic         busy_o;
    logic         cmd_done_o;
    logic         err_timeout_o;
    logic         last_kind_o;

    always #5 clk = ~clk;

    bt_cmd_scheduler #(
        .POLL_PERIOD(P), .ENC_TIMEOUT(T), .TX_FRAME_BYTES(NTX), .RX_FRAME_BYTES(NRX)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
        .poll_enable_i(poll_enable_i),
        .enc_start_o(enc_start_o), .enc_cmd_select_o(enc_cmd_select_o),
        .enc_input_data_o(enc_input_data_o), .enc_done_i(enc_done_i),
        .enc_output_data_i(enc_output_data_i),
        .uart_data_o(uart_data_o), .uart_valid_o(uart_valid_o), .uart_ready_i(uart_ready_i),
        .busy_o(busy_o), .cmd_done_o(cmd_done_o), .err_timeout_o(err_timeout_o),
        .last_kind_o(last_kind_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] tx_lit [18] = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52,
                                8'h54, 8'h54, 8'h58, 8'h3D, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
    logic [7:0] bp_lit [18] = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52,
                                8'h54, 8'h54, 8'h58, 8'h3D, 8'hD8, 8'hC7, 8'hB6, 8'hA5, 8'h0D};
    logic [7:0] rx_lit [13] = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52,
                                8'h54, 8'h52, 8'h58, 8'h0D};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame content the encoder produces: ASCII header, payload bytes LSB first for TX, then CR.
    function automatic logic [143:0] build_frame(input logic rx, input logic [31:0] d);
        logic [143:0] f;
        string h;
        int n;
        f = '0;
        h = rx ? "AT+BLEUARTRX" : "AT+BLEUARTTX=";
        for (int i = 0; i < h.len(); i++) f[8*i +: 8] = h.getc(i);
        n = h.len();
        if (!rx) begin
            for (int j = 0; j < 4; j++) f[8*(n+j) +: 8] = d[8*j +: 8];
            n = n + 4;
        end
        f[8*n +: 8] = 8'h0D;
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Encoder model: done drops one cycle after start, rises one cycle later with the frame.
    logic enc_stuck = 1'b0;
    initial begin : enc_model
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                ph = 0;
                enc_done_i = 1'b1;
            end else if (ph == 1) begin
                enc_done_i = 1'b0;
                ph = 2;
            end else if (ph == 2) begin
                enc_done_i = 1'b1;
                enc_output_data_i = build_frame(enc_cmd_select_o == 4'd2, enc_input_data_o);
                ph = 0;
            end else if (enc_start_o && !(enc_stuck ||
                         (enc_cmd_select_o == 4'd1 && enc_input_data_o[7:0] == 8'hEE))) begin
                ph = 1;
            end
        end
    end

    int rdy_mode = 0;
    initial begin : rdy_drv
        int bp_ph;
        bp_ph = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: uart_ready_i = 1'b1;
                1: begin
                    uart_ready_i = (bp_ph == 0 || bp_ph == 3);
                    bp_ph = (bp_ph + 1) % 4;
                end
                default: uart_ready_i = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Observation logs used by the directed checks.
    logic [7:0] acc_log [$];
    logic [3:0] sel_log [$];
    int         start_log [$];
    int tr_cnt, tr_cyc, first_v_cyc, done_cnt, err_cnt, err_cyc, uvalid_cnt;

    task automatic clear_logs();
        acc_log.delete();
        sel_log.delete();
        start_log.delete();
        tr_cnt = 0; tr_cyc = -1; first_v_cyc = -1;
        done_cnt = 0; err_cnt = 0; err_cyc = -1; uvalid_cnt = 0;
    endtask

    // Reference model: one command in flight, tracked as cycles since grant and bytes accepted.
    logic         m_act, m_last, m_pend, m_stuck, m_done_p, m_err_p;
    int           m_cnt, m_t, m_sent, m_n;
    logic [3:0]   m_sel;
    logic [31:0]  m_data;
    logic [143:0] m_frame;

    initial forever begin : compare
        logic g_tx, g_rx, e_uv, wrap, nd, ne;
        @(negedge clk);
        if (reset) begin
            check("rst_flags", {tx_ready_o, enc_start_o, uart_valid_o, busy_o, cmd_done_o,
                                err_timeout_o, last_kind_o}, 7'b0000001);
            check("rst_buses", {enc_cmd_select_o, enc_input_data_o, uart_data_o}, 44'h0);
            m_act = 0; m_last = 1; m_pend = 0; m_cnt = 0; m_sel = 0; m_data = 0;
            m_done_p = 0; m_err_p = 0; m_t = 0; m_sent = 0; m_stuck = 0;
        end else begin
            g_tx = !m_act && tx_valid_i && (!m_pend || m_last);
            g_rx = !m_act && m_pend && (!tx_valid_i || !m_last);
            e_uv = m_act && !m_stuck && (m_t >= 4);
            check("busy", busy_o, m_act);
            check("tx_ready", tx_ready_o, g_tx);
            check("enc_start", enc_start_o, m_act && m_t == 1);
            check("uart_valid", uart_valid_o, e_uv);
            if (e_uv) check($sformatf("uart_data[%0d]", m_sent), uart_data_o, m_frame[8*m_sent +: 8]);
            check("cmd_done", cmd_done_o, m_done_p);
            check("err_timeout", err_timeout_o, m_err_p);
            check("last_kind", last_kind_o, m_last);
            if (m_act && m_t >= 1 && !e_uv) begin
                check("enc_cmd_select", enc_cmd_select_o, m_sel);
                check("enc_input_data", enc_input_data_o, m_data);
            end

            if (uart_valid_o) begin
                uvalid_cnt++;
                if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (uart_valid_o && uart_ready_i) acc_log.push_back(uart_data_o);
            if (tx_ready_o) begin tr_cnt++; tr_cyc = cyc; end
            if (cmd_done_o) done_cnt++;
            if (err_timeout_o) begin err_cnt++; err_cyc = cyc; end
            if (enc_start_o) begin sel_log.push_back(enc_cmd_select_o); start_log.push_back(cyc); end

            wrap = poll_enable_i && (m_cnt == P - 1);
            m_cnt = (!poll_enable_i || wrap) ? 0 : m_cnt + 1;
            nd = 0; ne = 0;
            if (m_act) begin
                if (m_stuck) begin
                    if (m_t == 1 + T) begin m_act = 0; ne = 1; end
                end else if (e_uv && uart_ready_i) begin
                    m_sent++;
                    if (m_sent == m_n) begin m_act = 0; nd = 1; end
                end
                m_t++;
            end else if (g_tx || g_rx) begin
                m_act = 1; m_t = 1; m_sent = 0; m_last = g_rx;
                m_sel = g_rx ? 4'd2 : 4'd1;
                m_data = g_tx ? tx_data_i : 32'd0;
                m_frame = build_frame(g_rx, tx_data_i);
                m_n = g_rx ? NRX : NTX;
                m_stuck = enc_stuck || (g_tx && tx_data_i[7:0] == 8'hEE);
            end
            if (wrap) m_pend = 1;
            else if (g_rx) m_pend = 0;
            m_done_p = nd;
            m_err_p = ne;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin tick(); k++; end
        check("cmd_done_count", done_cnt, n);
    endtask

    task automatic send_tx(input logic [31:0] d);
        int k = 0;
        tick();
        tx_valid_i = 1'b1;
        tx_data_i = d;
        @(negedge clk);
        while (!tx_ready_o && k < 60) begin @(negedge clk); k++; end
        check("tx_accept", tx_ready_o, 1'b1);
        tick();
        tx_valid_i = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
        $fatal(1, "watchdog");
    end

    initial begin : main
        clear_logs();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single TX with an always-ready UART.
        clear_logs();
        send_tx(32'h44434241);
        wait_done(1, 100);
        check("tx_len", acc_log.size(), 18);
        if (acc_log.size() == 18)
            for (int i = 0; i < 18; i++) check($sformatf("tx_byte%0d", i), acc_log[i], tx_lit[i]);
        check("tx_ready_cycles", tr_cnt, 1);
        check("grant_to_valid", first_v_cyc - tr_cyc, 4);

        // Back-pressure pattern 1-0-0-1.
        clear_logs();
        rdy_mode = 1;
        send_tx(32'hA5B6C7D8);
        wait_done(1, 200);
        rdy_mode = 0;
        check("bp_len", acc_log.size(), 18);
        if (acc_log.size() == 18)
            for (int i = 0; i < 18; i++) check($sformatf("bp_byte%0d", i), acc_log[i], bp_lit[i]);

        // Periodic RX poll.
        clear_logs();
        poll_enable_i = 1'b1;
        wait_done(2, 200);
        poll_enable_i = 1'b0;
        check("rx_starts", sel_log.size(), 2);
        check("rx_len", acc_log.size(), 26);
        if (sel_log.size() >= 2) begin
            check("rx_sel0", sel_log[0], 4'd2);
            check("rx_sel1", sel_log[1], 4'd2);
            check("rx_period", start_log[1] - start_log[0], P);
        end
        if (acc_log.size() >= 13)
            for (int i = 0; i < 13; i++) check($sformatf("rx_byte%0d", i), acc_log[i], rx_lit[i]);
        repeat (10) tick();

        // Competing requests after a fresh reset: kinds must alternate.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        tx_valid_i = 1'b1;
        tx_data_i = 32'h01020304;
        poll_enable_i = 1'b1;
        begin
            int k = 0;
            while (sel_log.size() < 4 && k < 300) begin tick(); k++; end
        end
        tx_valid_i = 1'b0;
        poll_enable_i = 1'b0;
        check("rr_starts", sel_log.size() >= 4, 1'b1);
        if (sel_log.size() >= 4) begin
            check("rr_kind0", sel_log[0], 4'd1);
            check("rr_kind1", sel_log[1], 4'd2);
            check("rr_kind2", sel_log[2], 4'd1);
            check("rr_kind3", sel_log[3], 4'd2);
        end
        repeat (80) tick();

        // Encoder never goes busy: timeout, no bytes.
        clear_logs();
        enc_stuck = 1'b1;
        send_tx(32'h55667788);
        begin
            int k = 0;
            while (err_cnt < 1 && k < 50) begin tick(); k++; end
        end
        check("to_err_count", err_cnt, 1);
        if (start_log.size() == 1) check("to_delay", err_cyc - (start_log[0] + 1), T);
        check("to_no_valid", uvalid_cnt, 0);
        check("to_no_done", done_cnt, 0);
        tick();
        check("to_idle", busy_o, 1'b0);
        enc_stuck = 1'b0;

        // Reset while byte 7 of a TX frame is on the bus.
        clear_logs();
        send_tx(32'h44434241);
        begin
            int k = 0;
            while (acc_log.size() < 7 && k < 100) begin tick(); k++; end
        end
        check("mid_bytes", acc_log.size(), 7);
        check("mid_valid_before", uart_valid_o, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_flags", {tx_ready_o, enc_start_o, uart_valid_o, busy_o, cmd_done_o,
                                err_timeout_o, last_kind_o}, 7'b0000001);
        check("mid_rst_buses", {enc_cmd_select_o, enc_input_data_o, uart_data_o}, 44'h0);
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        send_tx(32'h44434241);
        wait_done(1, 100);
        check("fresh_len", acc_log.size(), 18);
        if (acc_log.size() == 18)
            for (int i = 0; i < 18; i++) check($sformatf("fresh_byte%0d", i), acc_log[i], tx_lit[i]);

        // Randomised traffic against the reference model.
        rdy_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            tx_valid_i = ($urandom_range(0, 9) < 3);
            tx_data_i = $urandom;
            if ($urandom_range(0, 7) == 0) tx_data_i[7:0] = 8'hEE;
            if ($urandom_range(0, 63) == 0) poll_enable_i = !poll_enable_i;
        end
        tx_valid_i = 1'b0;
        poll_enable_i = 1'b0;
        rdy_mode = 0;
        repeat (100) tick();
        check("final_idle", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
